cache_line_fill_ctrl: RTL
=========================

// Module: cache_line_fill_ctrl
// PURPOSE
//  Parametrised miss-fill controller between the cache tag/data arrays and a pipelined, in-order memory port.
//  - On a miss, fetches a full cache line as WORDS = LINE_BYTES/WORD_BYTES word reads.
//  - Keeps up to MAX_OUT reads in flight at once.
//  - Writes each returned word into the data array, then writes the tag.
//  - Delivers the missed (critical) word early so the pipeline can resume.
//  - Optional critical-word-first request ordering with wrap-around.
// PARAMETERS
//  ADDR_W      16  address width (bytes)
//  DATA_W      16  memory/data-array word width
//  LINE_BYTES  16  cache line size in bytes (power of 2, >= 2*WORD_BYTES)
//  WORD_BYTES   2  bytes per memory word (power of 2)
//  MAX_OUT      4  max outstanding memory reads (1..WORDS)
//  CRIT_FIRST   1  1: issue from missed word, wrapping; 0: issue from word 0 upward
// PORTS
//  clk                 in   1              clock, rising edge
//  rst_n               in   1              asynchronous reset, active low
//  miss_detected       in   1              tag logic reports a miss this cycle
//  miss_address        in   ADDR_W         byte address that missed
//  fsm_busy            out  1              fill in progress (pipeline stall)
//  mem_req             out  1              read request valid this cycle
//  memory_address      out  ADDR_W         byte address of the current request
//  memory_data         in   DATA_W         read data returned by memory
//  memory_data_valid   in   1              memory_data valid (in request order)
//  write_data_array    out  1              data-array write enable
//  write_word_sel      out  log2(WORDS)    word index within the line being written
//  write_tag_array     out  1              tag-array write enable (one cycle)
//  crit_valid          out  1              critical word is on crit_data this cycle
//  crit_data           out  DATA_W         critical word; holds its value until the next miss
//  fill_done           out  1              one-cycle pulse, line complete
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - State returns to IDLE; all counters cleared.
//    - All outputs 0, including crit_data and memory_address.
//  - Field widths: OFF_B = log2(LINE_BYTES); WRD_B = log2(WORD_BYTES).
//  - Miss capture: a miss is accepted only in IDLE. The block then latches:
//    - base = {miss_address[ADDR_W-1:OFF_B], 0}
//    - crit = miss_address[OFF_B-1:WRD_B]
//  - Request word index = (iss_cnt + (CRIT_FIRST ? crit : 0)) mod WORDS.
//    - memory_address = base + idx*WORD_BYTES. No carry leaves the line.
//    - memory_address is 0 whenever mem_req = 0.
//  - Response word index = (rsp_cnt + (CRIT_FIRST ? crit : 0)) mod WORDS. This drives write_word_sel.
//  - Outstanding counter: out = out + mem_req - accepted_valid. A request and a response in the same cycle leave it unchanged.
//  - FSM states:
//    - IDLE:
//      - miss_detected -> REQ next cycle; latch base and crit; clear iss_cnt, rsp_cnt, out.
//    - REQ:
//      - mem_req = 1 when out < MAX_OUT.
//      - After issuing word WORDS-1 -> WAIT, or -> DONE if that word's response also arrives in the same cycle.
//    - WAIT:
//      - No requests.
//      - Accepting the last response (rsp_cnt = WORDS-1) -> DONE.
//    - DONE (1 cycle):
//      - write_tag_array = 1, fill_done = 1; then -> IDLE.
//  - Outputs per state:
//    - fsm_busy = 1 in REQ, WAIT and DONE.
//    - fsm_busy is also 1 combinationally in IDLE when miss_detected = 1, so the stall starts on the miss cycle.
//  - Response handling:
//    - memory_data_valid is accepted only in REQ or WAIT.
//    - On acceptance: write_data_array = 1, same cycle, combinational.
//    - A valid in IDLE or DONE is ignored and produces no write.
//  - Critical word:
//    - When the accepted response index equals crit: crit_valid = 1 and crit_data = memory_data in that same cycle (bypass).
//    - crit_data is registered and holds its value afterwards.
//  - Latency (LAT = memory latency, CRIT_FIRST = 1):
//    - Miss at cycle 0 -> first mem_req at cycle 1 -> crit_valid at cycle 1+LAT.
//  - Ignored inputs: miss_detected while busy is ignored. miss_address is sampled only at capture.
//  - Reset mid-fill: abandons the line with no tag write. Responses still in flight after reset are not accepted, because the block is in IDLE.
// TESTING
//  - Sequential miss, CRIT_FIRST=0, MAX_OUT=4, mem LAT=4, miss_address=0x1236 ->
//    - requests 0x1230..0x123E, one per cycle, cycles 1-8;
//    - writes to words 0..7, cycles 5-12;
//    - crit_valid at cycle 8 (word 3);
//    - write_tag_array and fill_done at cycle 13.
//  - CRIT_FIRST=1, same miss ->
//    - request order 0x1236, 0x1238 ... 0x123E, 0x1230 ... 0x1234;
//    - crit_valid at cycle 5 with crit_data = mem[0x1236];
//    - write_word_sel sequence 3,4,5,6,7,0,1,2.
//  - MAX_OUT=2, LAT=4 -> mem_req never exceeds 2 outstanding; req pattern 2-on, 2-off; 8 words written; one tag write.
//  - Spurious memory_data_valid in IDLE, and miss_detected asserted during WAIT -> no write_data_array, no second fill.
//  - rst_n low after 3 words written, then a stale valid arrives -> all outputs 0; no tag write; next miss fills normally.

Source files
------------

// File: rtl/cache_line_fill_ctrl.sv
// Miss-fill controller: fetches a cache line as pipelined word reads, writes the data
// array as words return, forwards the missed word early, then writes the tag.
module cache_line_fill_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LINE_BYTES = 16,
    parameter int WORD_BYTES = 2,
    parameter int MAX_OUT    = 4,
    parameter int CRIT_FIRST = 1,
    localparam int WORDS     = LINE_BYTES / WORD_BYTES,
    localparam int IDX_W     = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] memory_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              write_data_array,
    output logic [IDX_W-1:0]  write_word_sel,
    output logic              write_tag_array,
    output logic              crit_valid,
    output logic [DATA_W-1:0] crit_data,
    output logic              fill_done
);
    localparam int OFF_B = $clog2(LINE_BYTES);
    localparam int WRD_B = $clog2(WORD_BYTES);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(WORDS - 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                   state, state_nxt;
    logic [ADDR_W-OFF_B-1:0]  base_q;
    logic [IDX_W-1:0]         crit_q, iss_cnt, rsp_cnt, rot, iss_idx, rsp_idx;
    logic [OUT_W-1:0]         out_cnt;
    logic [DATA_W-1:0]        crit_data_q;
    logic                     capture, accept, crit_hit;

    // Byte-within-word bits never select anything.
    if (WRD_B > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^miss_address[WRD_B-1:0];
    end

    assign rot     = (CRIT_FIRST != 0) ? crit_q : '0;
    assign iss_idx = iss_cnt + rot;
    assign rsp_idx = rsp_cnt + rot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (miss_detected) state_nxt = REQ;
            REQ:  if (mem_req && iss_cnt == LAST)
                      state_nxt = (accept && rsp_cnt == LAST) ? DONE : WAIT;
            WAIT: if (accept && rsp_cnt == LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture          = (state == IDLE) && miss_detected;
        fsm_busy         = (state != IDLE) || miss_detected;
        accept           = memory_data_valid && (state == REQ || state == WAIT);
        // A response retiring this cycle frees its slot for a same-cycle request.
        mem_req          = (state == REQ) && ((out_cnt < OUT_MAX) || accept);
        memory_address   = mem_req ? (ADDR_W'({base_q, iss_idx}) << WRD_B) : '0;
        write_data_array = accept;
        write_word_sel   = accept ? rsp_idx : '0;
        crit_hit         = accept && (rsp_idx == crit_q);
        crit_valid       = crit_hit;
        crit_data        = crit_hit ? memory_data : crit_data_q;
        write_tag_array  = (state == DONE);
        fill_done        = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            crit_q      <= '0;
            iss_cnt     <= '0;
            rsp_cnt     <= '0;
            out_cnt     <= '0;
            crit_data_q <= '0;
        end else begin
            if (capture) begin
                base_q  <= miss_address[ADDR_W-1:OFF_B];
                crit_q  <= miss_address[OFF_B-1:WRD_B];
                iss_cnt <= '0;
                rsp_cnt <= '0;
                out_cnt <= '0;
            end else begin
                if (mem_req) iss_cnt <= iss_cnt + IDX_W'(1);
                if (accept)  rsp_cnt <= rsp_cnt + IDX_W'(1);
                case ({mem_req, accept})
                    2'b10:   out_cnt <= out_cnt + OUT_W'(1);
                    2'b01:   out_cnt <= out_cnt - OUT_W'(1);
                    default: out_cnt <= out_cnt;
                endcase
            end
            if (crit_hit) crit_data_q <= memory_data;
        end
    end
endmodule
